// File: rtl/risc_test_pkg.sv
// Shared types and constants for the RISC_16 vector sequencer.
package risc_test_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Bit positions inside fail_mask
    localparam int FAIL_IN1 = 0;
    localparam int FAIL_IN2 = 1;
    localparam int FAIL_OUT = 2;

endpackage

// File: rtl/risc_vec_mem.sv
// Vector table: DEPTH slots of {instr, exp_in1, exp_in2, exp_out},
// one synchronous write port and one registered read port.
module risc_vec_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [4*DATA_W-1:0]        wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [4*DATA_W-1:0]        rdata
);

    logic [4*DATA_W-1:0] mem_q [DEPTH];
    logic [4*DATA_W-1:0] rdata_q;

    // Table write and registered read
    // NOTE: the table and its read register have no reset; contents are only
    // meaningful after a load, and leaving them unreset keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/risc_test_sequencer.sv
// Vector sequencer/checker for the RISC_16 core: issues each stored
// instruction with a timed enable window, then checks the ALU debug taps.
module risc_test_sequencer
    import risc_test_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 8,
    parameter int CYCLES_PER_TEST = 5,
    parameter int ERR_W           = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_tests,
    input  logic                       stop_on_fail,
    input  logic                       vec_we,
    input  logic [$clog2(DEPTH)-1:0]   vec_addr,
    input  logic [DATA_W-1:0]          vec_instr,
    input  logic [DATA_W-1:0]          vec_exp_in1,
    input  logic [DATA_W-1:0]          vec_exp_in2,
    input  logic [DATA_W-1:0]          vec_exp_out,
    output logic                       dut_enable,
    output logic [DATA_W-1:0]          dut_instruction,
    input  logic [DATA_W-1:0]          alu_in1,
    input  logic [DATA_W-1:0]          alu_in2,
    input  logic [DATA_W-1:0]          alu_out,
    output logic                       busy,
    output logic                       done,
    output logic [ERR_W-1:0]           error_count,
    output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
    output logic                       fail_valid,
    output logic [2:0]                 fail_mask,
    output logic [$clog2(DEPTH)-1:0]   vec_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = (CYCLES_PER_TEST > 1) ? $clog2(CYCLES_PER_TEST) : 1;

    localparam logic [NW-1:0]    DEPTH_N  = NW'(DEPTH);
    localparam logic [CW-1:0]    CYC_LAST = CW'(CYCLES_PER_TEST - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t              state_q, state_d;
    logic [AW-1:0]       vec_idx_q, vec_idx_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [NW-1:0]       num_q, num_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [AW-1:0]       ffi_q, ffi_d;
    logic                fv_q, fv_d;
    logic [2:0]          fmask_q, fmask_d;

    logic [4*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]   rd_instr, rd_exp_in1, rd_exp_in2, rd_exp_out;
    logic [2:0]          mask_w;
    logic [NW-1:0]       num_clamped;
    logic                is_last;
    logic                busy_w;

    assign busy_w = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                    (state_q == ST_SETTLE) || (state_q == ST_CHECK);

    // Writes are only accepted between runs, so the table never changes under a run
    risc_vec_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (vec_we && !busy_w),
        .waddr (vec_addr),
        .wdata ({vec_instr, vec_exp_in1, vec_exp_in2, vec_exp_out}),
        .re    (state_q == ST_FETCH),
        .raddr (vec_idx_q),
        .rdata (rd_data)
    );

    assign {rd_instr, rd_exp_in1, rd_exp_in2, rd_exp_out} = rd_data;

    // Per-field compare of the core taps against the fetched vector
    always_comb begin
        mask_w           = '0;
        mask_w[FAIL_IN1] = (alu_in1 != rd_exp_in1);
        mask_w[FAIL_IN2] = (alu_in2 != rd_exp_in2);
        mask_w[FAIL_OUT] = (alu_out != rd_exp_out);
    end

    assign num_clamped = (num_tests > DEPTH_N) ? DEPTH_N : num_tests;
    assign is_last     = ({1'b0, vec_idx_q} == (num_q - NW'(1)));

    // Next-state logic for the FSM, counters and result registers
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        cyc_d     = cyc_q;
        num_d     = num_q;
        err_d     = err_q;
        ffi_d     = ffi_q;
        fv_d      = fv_q;
        fmask_d   = fmask_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d     = '0;
                    ffi_d     = '0;
                    fv_d      = 1'b0;
                    fmask_d   = '0;
                    vec_idx_d = '0;
                    num_d     = num_clamped;
                    state_d   = (num_clamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                cyc_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cyc_q == CYC_LAST) begin
                    state_d = ST_SETTLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mask_w != '0) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    fmask_d = mask_w;
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffi_d = vec_idx_q;
                    end
                end
                if (is_last || ((mask_w != '0) && stop_on_fail)) begin
                    state_d = ST_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + AW'(1);
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            cyc_q     <= '0;
            num_q     <= '0;
            err_q     <= '0;
            ffi_q     <= '0;
            fv_q      <= 1'b0;
            fmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            cyc_q     <= cyc_d;
            num_q     <= num_d;
            err_q     <= err_d;
            ffi_q     <= ffi_d;
            fv_q      <= fv_d;
            fmask_q   <= fmask_d;
        end
    end

    assign dut_enable      = (state_q == ST_ISSUE);
    assign dut_instruction = ((state_q == ST_ISSUE) || (state_q == ST_SETTLE)) ? rd_instr : '0;
    assign busy            = busy_w;
    assign done            = (state_q == ST_DONE);
    assign error_count     = err_q;
    assign first_fail_idx  = ffi_q;
    assign fail_valid      = fv_q;
    assign fail_mask       = fmask_q;
    assign vec_idx         = vec_idx_q;

endmodule

// File: doc/risc_test_sequencer.md
# risc_test_sequencer

Parametrised, synthesisable vector sequencer and checker for the RISC_16 core. It holds a loadable table of instruction vectors with expected ALU operand and result values. On command it issues each vector to the core with a gated `enable` window, then compares the core's ALU debug taps against the expected values. Errors, the first failing index and a per-field fail mask are accumulated, so regression runs on the board or in simulation are self-checking.

## Interface
Parameters:
- DATA_W, 16, width of instruction and ALU tap words
- DEPTH, 8, number of vector slots (power of two, ≥2)
- CYCLES_PER_TEST, 5, clock cycles `dut_enable` is held high per vector (≥1)
- ERR_W, 8, width of the error counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin run; sampled in IDLE/DONE only
- num_tests  in  $clog2(DEPTH)+1  vectors to run, 0..DEPTH
- stop_on_fail  in  1  1 = end run at first failing vector
- vec_we  in  1  vector table write strobe
- vec_addr  in  $clog2(DEPTH)  vector slot
- vec_instr, vec_exp_in1, vec_exp_in2, vec_exp_out  in  DATA_W each  vector fields
- dut_enable  out  1  to core `enable`
- dut_instruction  out  DATA_W  to core `instruction`
- alu_in1, alu_in2, alu_out  in  DATA_W each  from core `t_alu_in1/in2/out`
- busy  out  1  run in progress
- done  out  1  run finished; level
- error_count  out  ERR_W  failing vectors, saturating
- first_fail_idx  out  $clog2(DEPTH)  index of first failing vector
- fail_valid  out  1  at least one failure this run
- fail_mask  out  3  last failing vector: bit0 in1, bit1 in2, bit2 out
- vec_idx  out  $clog2(DEPTH)  current or last-checked vector

## Operation
- States: IDLE, FETCH, ISSUE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: clear error_count, fail_valid, fail_mask, first_fail_idx, vec_idx; go to FETCH, or to DONE directly if num_tests==0.
- FETCH (1 cycle): table read of slot vec_idx is issued; it returns registered.
- ISSUE (CYCLES_PER_TEST cycles): dut_instruction = vec_instr; dut_enable = 1.
- SETTLE (1 cycle): dut_enable = 0; dut_instruction is held.
- CHECK (1 cycle): each tap is compared with its own expected field. On any mismatch: error_count+1 (saturate at all-ones), fail_mask updated, and first_fail_idx/fail_valid set if fail_valid was 0.
- After CHECK: go to DONE if vec_idx==num_tests-1 or (mismatch && stop_on_fail); otherwise vec_idx+1 and go to FETCH.
- DONE: done=1, busy=0, results held until the next start or rst.
- vec_we is accepted only when busy=0; it is ignored while busy. A start in the same cycle as vec_we is accepted, and the write completes first.
- start while busy is ignored.
- num_tests > DEPTH is clamped to DEPTH.

## Timing
- Reset values: all outputs 0; state IDLE. Vector table contents are not reset.
- busy rises the cycle after start is accepted.
- Per-vector latency: CYCLES_PER_TEST+3 cycles.
- A full run with no stop takes num_tests·(CYCLES_PER_TEST+3) cycles from busy↑ to done↑. With num_tests==0, done rises 1 cycle after start.
- Taps are sampled in CHECK, i.e. one cycle after enable falls. The core's taps must be stable by then.
- rst mid-run: dut_enable=0 and state IDLE at the next edge. A partial run leaves no residue.
- Table write latency: 1 cycle. A FETCH of the same slot in the next cycle returns the new data.

## Structure
- Package risc_test_pkg holds:
  - the state enum
  - fail_mask bit-position constants (FAIL_IN1=0, FAIL_IN2=1, FAIL_OUT=2)
- Sub-module risc_vec_mem holds the DEPTH × (4·DATA_W) table: one synchronous write port and one registered read port. The FSM, counters and compare logic stay in the top module.

## Test plan
(All scenarios use DATA_W=16, DEPTH=8, CYCLES_PER_TEST=5, with a behavioural core model driving the taps.)
- Reset: assert rst for 2 cycles -> all outputs 0, busy=0, done=0.
- Single pass: load slot0 = {16'h1001, 1, 1, 2}, model matches, num_tests=1, start -> dut_enable high exactly 5 cycles; done at busy↑+8; error_count=0, fail_valid=0.
- In2-only mismatch: model drives alu_in2=3 against expected 1 -> fail_mask=3'b010, error_count=1, first_fail_idx=0. This confirms in2 is checked against exp_in2.
- Multi-vector, stop_on_fail=0: num_tests=4, vectors 1 and 3 fail -> error_count=2, first_fail_idx=1, done at +32. Same run with stop_on_fail=1 -> done at +16, vec_idx=1.
- Edge cases:
  - num_tests=0 -> done 1 cycle after start, dut_enable never high.
  - start and vec_we while busy -> both ignored.
- Reset mid-ISSUE -> dut_enable=0 next cycle, state IDLE. The table is retained, and a rerun of the scenario 3 table reproduces its result.
